// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU data-memory path.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int          DATA_W    = 16;
    localparam int          BE_LO     = 0;
    localparam int          BE_HI     = 1;
    localparam logic [15:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/data_mem_array.sv
// Single-port synchronous data RAM, per-byte write enable, registered read.
import cpu_pkg::*;

module data_mem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [1:0]        be,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read register only updates on a load, so it holds for the whole response.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                if (be[BE_LO]) mem[addr][7:0]  <= wdata[7:0];
                if (be[BE_HI]) mem[addr][15:8] <= wdata[15:8];
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage load/store responder: wait-state FSM, range check and stall counter.
import cpu_pkg::*;

module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_be,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [15:0]       stall_count
);

    localparam int         MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t              state;
    logic [3:0]          cnt;
    logic                we_q;
    logic [1:0]          be_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                rd_sel;
    logic [DATA_W-1:0]   ram_rdata;

    logic                cur_we;
    logic [1:0]          cur_be;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_wdata;
    logic                cur_err;
    logic                enter_resp;

    assign req_ready = (state == IDLE);

    // With zero latency the commit happens on the acceptance edge, so use the live request.
    assign cur_we    = (state == IDLE) ? req_we    : we_q;
    assign cur_be    = (state == IDLE) ? req_be    : be_q;
    assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign cur_err   = (64'(cur_addr) >= 64'(DEPTH));

    assign enter_resp = ((state == IDLE) && req_valid && (LATENCY == 0)) ||
                        ((state == WAIT) && (cnt == 4'd0));

    assign resp_rdata = rd_sel ? ram_rdata : '0;

    data_mem_array #(
        .DEPTH(DEPTH),
        .AW   (MEM_AW)
    ) u_array (
        .clk  (clk),
        .en   (enter_resp && !cur_err),
        .we   (cur_we),
        .be   (cur_be),
        .addr (cur_addr[MEM_AW-1:0]),
        .wdata(cur_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            we_q        <= 1'b0;
            be_q        <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            rd_sel      <= 1'b0;
            stall_count <= '0;
        end else begin
            if (req_valid && !req_ready && (stall_count != STALL_MAX))
                stall_count <= stall_count + 16'd1;

            if (enter_resp) begin
                state      <= RESP;
                resp_valid <= 1'b1;
                resp_err   <= cur_err;
                rd_sel     <= !cur_we && !cur_err;
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        be_q    <= req_be;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (LATENCY != 0) begin
                            cnt   <= CNT_LOAD;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        rd_sel     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 instance plus a LATENCY=0 instance.
module tb_data_mem_responder;

    localparam int LAT_A = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    always #5 clk = ~clk;

    logic        req_valid, req_we, resp_ready;
    logic [1:0]  req_be;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [15:0] resp_rdata, stall_count;

    logic        v0, we0, rr0;
    logic [1:0]  be0;
    logic [15:0] addr0, wd0;
    logic        rdy0, rv0, err0;
    logic [15:0] rd0, sc0;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] ref_mem [0:255];

    data_mem_responder #(.DEPTH(256), .ADDR_W(16), .LATENCY(LAT_A)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .stall_count(stall_count)
    );

    data_mem_responder #(.DEPTH(256), .ADDR_W(16), .LATENCY(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .req_valid(v0), .req_ready(rdy0),
        .req_we(we0), .req_be(be0), .req_addr(addr0), .req_wdata(wd0),
        .resp_valid(rv0), .resp_ready(rr0), .resp_rdata(rd0),
        .resp_err(err0), .stall_count(sc0)
    );

    // One full transaction on the LATENCY=2 instance, holding the response for 'hold' cycles.
    task automatic do_req(input logic we, input logic [1:0] be, input logic [15:0] addr,
                          input logic [15:0] wd, input int hold,
                          output logic [15:0] rd, output logic err);
        int n;
        req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wd;
        resp_ready = 1'b0;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        // resp_valid first seen after edge N+LATENCY, i.e. present at edge N+LATENCY+1
        n_checks++;
        if (n != LAT_A) begin
            n_fail++;
            $display("FAIL latency addr=%h: resp_valid after %0d edges, want %0d", addr, n, LAT_A);
        end
        rd  = resp_rdata;
        err = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== err || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold addr=%h: valid=%b rdata=%h err=%b ready=%b, want 1 %h %b 0",
                         addr, resp_valid, resp_rdata, resp_err, req_ready, rd, err);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 16'h0 || resp_err !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release addr=%h: valid=%b rdata=%h err=%b ready=%b, want 0 0000 0 1",
                     addr, resp_valid, resp_rdata, resp_err, req_ready);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 16'h0 || resp_err !== 1'b0 ||
            stall_count !== 16'h0 || req_ready !== 1'b1 || rv0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: valid=%b rdata=%h err=%b stall=%h ready=%b valid0=%b, want 0 0000 0 0000 1 0",
                     resp_valid, resp_rdata, resp_err, stall_count, req_ready, rv0);
        end
    endtask

    task automatic test_store_load();
        logic [15:0] rd; logic err;
        do_req(1'b1, 2'b11, 16'h0010, 16'h1234, 0, rd, err);
        ref_mem[8'h10] = 16'h1234;
        n_checks++;
        if (rd !== 16'h0 || err !== 1'b0) begin
            n_fail++; $display("FAIL store_ack: rdata=%h err=%b, want 0000 0", rd, err);
        end
        do_req(1'b0, 2'b00, 16'h0010, 16'h0, 1, rd, err);
        n_checks++;
        if (rd !== 16'h1234 || err !== 1'b0) begin
            n_fail++; $display("FAIL load_back: rdata=%h err=%b, want 1234 0", rd, err);
        end
    endtask

    task automatic test_byte_store();
        logic [15:0] rd; logic err;
        do_req(1'b1, 2'b01, 16'h0010, 16'hFFAB, 0, rd, err);
        ref_mem[8'h10] = 16'h12AB;
        do_req(1'b0, 2'b11, 16'h0010, 16'h0, 0, rd, err);
        n_checks++;
        if (rd !== 16'h12AB) begin
            n_fail++; $display("FAIL byte_lo: rdata=%h, want 12ab", rd);
        end
        do_req(1'b1, 2'b00, 16'h0010, 16'h5555, 0, rd, err);
        n_checks++;
        if (rd !== 16'h0 || err !== 1'b0) begin
            n_fail++; $display("FAIL be00_ack: rdata=%h err=%b, want 0000 0", rd, err);
        end
        do_req(1'b0, 2'b00, 16'h0010, 16'h0, 0, rd, err);
        n_checks++;
        if (rd !== 16'h12AB) begin
            n_fail++; $display("FAIL be00_keep: rdata=%h, want 12ab", rd);
        end
    endtask

    task automatic test_out_of_range();
        logic [15:0] rd; logic err;
        do_req(1'b1, 2'b11, 16'h0000, 16'h0F0F, 0, rd, err);
        ref_mem[8'h00] = 16'h0F0F;
        do_req(1'b1, 2'b11, 16'h0100, 16'hDEAD, 0, rd, err);
        n_checks++;
        if (rd !== 16'h0 || err !== 1'b1) begin
            n_fail++; $display("FAIL oor_store: rdata=%h err=%b, want 0000 1", rd, err);
        end
        do_req(1'b0, 2'b11, 16'h0100, 16'h0, 0, rd, err);
        n_checks++;
        if (rd !== 16'h0 || err !== 1'b1) begin
            n_fail++; $display("FAIL oor_load: rdata=%h err=%b, want 0000 1", rd, err);
        end
        do_req(1'b0, 2'b11, 16'h0000, 16'h0, 0, rd, err);
        n_checks++;
        if (rd !== 16'h0F0F || err !== 1'b0) begin
            n_fail++; $display("FAIL oor_alias: mem[0]=%h err=%b, want 0f0f 0", rd, err);
        end
    endtask

    task automatic test_back_pressure();
        logic [15:0] rd, held, sc_start; logic err;
        int n;
        sc_start = stall_count;
        req_valid = 1'b1; req_we = 1'b0; req_be = 2'b11; req_addr = 16'h0010; req_wdata = 16'h0;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        // next request queued immediately behind the accepted one
        req_we = 1'b1; req_addr = 16'h0011; req_wdata = 16'h5A5A;
        n = 0;
        while (resp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        held = resp_rdata;
        n_checks++;
        if (held !== 16'h12AB || n != LAT_A) begin
            n_fail++; $display("FAIL bp_first: rdata=%h edges=%0d, want 12ab %0d", held, n, LAT_A);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== held || req_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold: valid=%b rdata=%h ready=%b, want 1 %h 0",
                                   resp_valid, resp_rdata, req_ready, held);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: valid=%b ready=%b, want 0 1", resp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        // LATENCY wait edges + 4 held edges + the handshake edge
        n_checks++;
        if (req_ready !== 1'b0 || (stall_count - sc_start) !== 16'(LAT_A + 5)) begin
            n_fail++; $display("FAIL bp_stall: ready=%b stall_delta=%0d, want 0 %0d",
                               req_ready, stall_count - sc_start, LAT_A + 5);
        end
        n = 0;
        while (resp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        ref_mem[8'h11] = 16'h5A5A;
        do_req(1'b0, 2'b11, 16'h0011, 16'h0, 0, rd, err);
        n_checks++;
        if (rd !== 16'h5A5A || err !== 1'b0) begin
            n_fail++; $display("FAIL bp_queued: rdata=%h err=%b, want 5a5a 0", rd, err);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [15:0] rd; logic err;
        do_req(1'b1, 2'b11, 16'h0020, 16'h0000, 0, rd, err);
        ref_mem[8'h20] = 16'h0000;
        req_valid = 1'b1; req_we = 1'b1; req_be = 2'b11; req_addr = 16'h0020; req_wdata = 16'hBEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || stall_count !== 16'h0) begin
            n_fail++; $display("FAIL mid_wait_reset: valid=%b ready=%b stall=%h, want 0 1 0000",
                               resp_valid, req_ready, stall_count);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, 2'b11, 16'h0020, 16'h0, 0, rd, err);
        n_checks++;
        if (rd !== 16'h0000 || err !== 1'b0) begin
            n_fail++; $display("FAIL aborted_store: rdata=%h err=%b, want 0000 0", rd, err);
        end
    endtask

    task automatic test_random();
        logic [15:0] rd, a, w, exp_rd; logic err, we, exp_err; logic [1:0] be;
        for (int i = 0; i < 16; i++) begin
            a = 16'h0030 + 16'(i);
            w = 16'($urandom);
            do_req(1'b1, 2'b11, a, w, 0, rd, err);
            ref_mem[a[7:0]] = w;
        end
        for (int i = 0; i < 40; i++) begin
            a  = 16'h0030 + 16'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a = a | (($urandom_range(0, 1) == 1) ? 16'h0100 : 16'hFF00);
            we = 1'($urandom_range(0, 1));
            be = 2'($urandom_range(0, 3));
            w  = 16'($urandom);
            exp_err = (a >= 16'd256);
            exp_rd  = (!we && !exp_err) ? ref_mem[a[7:0]] : 16'h0;
            if (we && !exp_err) begin
                if (be[0]) ref_mem[a[7:0]][7:0]  = w[7:0];
                if (be[1]) ref_mem[a[7:0]][15:8] = w[15:8];
            end
            do_req(we, be, a, w, $urandom_range(0, 2), rd, err);
            n_checks++;
            if (rd !== exp_rd || err !== exp_err) begin
                n_fail++; $display("FAIL random[%0d] we=%b be=%b addr=%h: rdata=%h err=%b, want %h %b",
                                   i, we, be, a, rd, err, exp_rd, exp_err);
            end
        end
    endtask

    task automatic test_latency0();
        for (int k = 0; k < 2; k++) begin
            v0 = 1'b1; we0 = (k == 0); be0 = 2'b11; addr0 = 16'h0005; wd0 = 16'h00FF; rr0 = 1'b0;
            #1;
            n_checks++;
            if (rdy0 !== 1'b1) begin
                n_fail++; $display("FAIL lat0_ready[%0d]: ready=%b, want 1", k, rdy0);
            end
            @(posedge clk); #1;
            v0 = 1'b0;
            n_checks++;
            if (rv0 !== 1'b1 || err0 !== 1'b0 || rd0 !== ((k == 0) ? 16'h0000 : 16'h00FF)) begin
                n_fail++; $display("FAIL lat0_resp[%0d]: valid=%b err=%b rdata=%h, want 1 0 %h",
                                   k, rv0, err0, rd0, (k == 0) ? 16'h0000 : 16'h00FF);
            end
            rr0 = 1'b1;
            @(posedge clk); #1;
            rr0 = 1'b0;
            n_checks++;
            if (rv0 !== 1'b0 || rdy0 !== 1'b1) begin
                n_fail++; $display("FAIL lat0_release[%0d]: valid=%b ready=%b, want 0 1", k, rv0, rdy0);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_be = 2'b00; req_addr = 16'h0; req_wdata = 16'h0;
        resp_ready = 1'b0;
        v0 = 1'b0; we0 = 1'b0; be0 = 2'b00; addr0 = 16'h0; wd0 = 16'h0; rr0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset_n = 1'b1;
        @(posedge clk); #1;
        test_store_load();
        test_byte_store();
        test_out_of_range();
        test_back_pressure();
        test_reset_mid_wait();
        test_random();
        test_latency0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU's MEM-stage load/store interface. The pipeline's MEM stage is the initiator; this block accepts one request at a time, applies a configurable wait-state latency, then returns read data or a write acknowledge.
- Backs a word-addressed 16-bit data RAM.
- Exposes a stall counter so the testbench can monitor pipeline back-pressure cycles alongside the other CPU debug outputs.

Parameters:
- DEPTH, 256, number of 16-bit words; valid addresses are 0..DEPTH-1.
- ADDR_W, 16, width of req_addr.
- LATENCY, 2, wait-state cycles between acceptance and response; legal range 0..15.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  MEM stage presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_be  input  2  store byte enables: bit0 = [7:0], bit1 = [15:8]. Ignored on loads.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  16  store data.
- resp_valid  output  1  response available.
- resp_ready  input  1  initiator consumes the response.
- resp_rdata  output  16  load data; 0 for stores and errors.
- resp_err  output  1  address out of range; qualified by resp_valid.
- stall_count  output  16  saturating count of cycles with req_valid=1 and req_ready=0.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: state IDLE, resp_valid=0, resp_rdata=0, resp_err=0, stall_count=0, wait counter=0. req_ready is 1 as soon as reset_n deasserts.
- RAM contents are not reset. A load from an unwritten location returns X.
- FSM states: IDLE, WAIT, RESP.
- req_ready is 1 only in IDLE. It is decoded from state, not from req_valid.
- IDLE:
  - When req_valid && req_ready at a rising edge, latch we, be, addr and wdata.
  - If LATENCY=0, go to RESP; otherwise load the counter with LATENCY-1 and go to WAIT.
- WAIT:
  - Decrement the counter each edge.
  - On the edge where the counter is 0, go to RESP.
- Entry into RESP (same edge):
  - Set resp_err = (addr >= DEPTH).
  - Store, no error: write the enabled bytes; resp_rdata=0.
  - Load, no error: resp_rdata = mem[addr].
  - Any error: no RAM write; resp_rdata=0.
- Timing: resp_valid rises exactly LATENCY+1 edges after the acceptance edge.
- RESP:
  - resp_valid=1 with stable resp_rdata and resp_err until resp_valid && resp_ready at an edge.
  - Then clear resp_valid, resp_rdata and resp_err, and return to IDLE.
  - No new request is accepted in that same cycle. Minimum request spacing is LATENCY+2 cycles.
- Store with req_be=2'b00: RAM unchanged; a normal acknowledge is still returned.
- Back-to-back: a request held while req_ready=0 is accepted on the first IDLE edge, with no loss.
- stall_count increments on each edge where req_valid && !req_ready, and saturates at 16'hFFFF.
- Reset mid-operation: asserting reset_n=0 in WAIT aborts the transaction.
  - A store not yet committed (commit happens on RESP entry) is not written.
  - Reset in RESP drops the pending response.
  - Writes already committed are retained.
- Address width: the comparison against DEPTH uses the full ADDR_W bits. No aliasing or wrap of high address bits.

Decomposition:
- Shared package cpu_pkg holds:
  - the FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - DATA_W=16;
  - byte-enable bit positions;
  - STALL_MAX=16'hFFFF.
- One sub-module, data_mem_array: single-port synchronous RAM with per-byte write enable and registered read, DEPTH x 16. The FSM, counter and stall counter stay in data_mem_responder.

Test Plan:
- Store then load (LATENCY=2, resp_ready=1):
  - Store 16'h1234 to addr 16'h0010, be=2'b11, accepted at edge N → resp_valid at edge N+3, resp_err=0, resp_rdata=0.
  - Load 16'h0010 → resp_rdata=16'h1234.
- Byte store:
  - Store 16'hFFAB to 16'h0010 with be=2'b01 → load returns 16'h12AB.
  - Store with be=2'b00 → load still returns 16'h12AB, and the acknowledge is still seen.
- Out of range:
  - Store to 16'h0100 (DEPTH=256) → resp_err=1, resp_rdata=0.
  - Load 16'h0100 → resp_err=1, resp_rdata=0. No RAM location changes.
- Back-pressure:
  - Hold resp_ready=0 for 4 cycles while req_valid=1 with the next request queued → resp_valid and resp_rdata stay stable, req_ready=0.
  - stall_count increases by 4 plus the wait cycles.
  - The next request is accepted on the first edge after the response handshake.
- Reset mid-WAIT:
  - Store 16'hBEEF to 16'h0020 (previously 16'h0000), pulse reset_n low one cycle after acceptance → resp_valid=0, state IDLE, req_ready=1, stall_count=0.
  - Load 16'h0020 → 16'h0000.
- LATENCY=0 build: store then load 16'h00FF → each resp_valid rises one edge after acceptance, and readback is 16'h00FF.
